// File: rtl/hh_stim_if.sv
// Signal bundle between host/config, the stimulus sequencer and the neuron/monitor side.
// The master drives configuration, control and spike inputs; the slave is the sequencer.
interface hh_stim_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 16,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                   ena;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [DATA_W-1:0]      cfg_data;
  logic [AW-1:0]          cfg_last;
  logic [HOLD_W-1:0]      cfg_hold;
  logic [1:0]             cfg_mode;
  logic                   start;
  logic                   stop;
  logic [N_CH-1:0]        spike_in;

  logic [DATA_W-1:0]      i_out;
  logic [AW-1:0]          step_idx;
  logic                   busy;
  logic                   done;
  logic                   cnt_valid;
  logic [N_CH*CNT_W-1:0]  spike_cnt;
  logic [CNT_W-1:0]       coinc_cnt;

  modport master (
    output ena, cfg_we, cfg_addr, cfg_data, cfg_last, cfg_hold, cfg_mode,
    output start, stop, spike_in,
    input  i_out, step_idx, busy, done, cnt_valid, spike_cnt, coinc_cnt
  );

  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_data, cfg_last, cfg_hold, cfg_mode,
    input  start, stop, spike_in,
    output i_out, step_idx, busy, done, cnt_valid, spike_cnt, coinc_cnt
  );
endinterface

// File: rtl/hh_stim_sequencer.sv
// Stimulus-current sequencer: steps a level table (one-shot/loop/ping-pong) onto i_out
// and publishes per-step spike and coincidence totals at every step boundary.
module hh_stim_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 16,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16
) (
  input  logic     clk,
  input  logic     rst,
  hh_stim_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       MODE_LOOP = 2'b01;
  localparam logic [1:0]       MODE_PING = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      idx_reg, idx_next, adv_idx;
  logic [AW-1:0]      last_reg, last_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [1:0]         mode_reg, mode_next;
  logic               dir_down_reg, dir_down_next, adv_dir_down;
  logic [DATA_W-1:0]  i_out_reg, i_out_next;
  logic               cnt_valid_reg;
  logic               count_en, clear_run, publish, one_shot;
  logic [PW-1:0]      pop;
  logic               coinc_hit;
  logic [CNT_W-1:0]   coinc_run_reg, coinc_run_inc, coinc_pub_reg;
  logic [DATA_W-1:0]  level_mem [DEPTH];

  assign one_shot = (mode_reg != MODE_LOOP) && (mode_reg != MODE_PING);

  // Index and direction for the step after the current one (non-terminal cases).
  always_comb begin
    adv_idx      = idx_reg + 1'b1;
    adv_dir_down = dir_down_reg;
    if (mode_reg == MODE_LOOP) begin
      if (idx_reg == last_reg) adv_idx = '0;
    end else if (mode_reg == MODE_PING) begin
      if (last_reg == '0) begin
        adv_idx = '0;
      end else if (!dir_down_reg) begin
        if (idx_reg == last_reg) begin
          adv_idx      = idx_reg - 1'b1;
          adv_dir_down = 1'b1;
        end
      end else begin
        if (idx_reg == '0) begin
          adv_idx      = AW'(1);
          adv_dir_down = 1'b0;
        end else begin
          adv_idx = idx_reg - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    last_next     = last_reg;
    hold_next     = hold_reg;
    hold_cnt_next = hold_cnt_reg;
    mode_next     = mode_reg;
    dir_down_next = dir_down_reg;
    i_out_next    = i_out_reg;
    count_en      = 1'b0;
    clear_run     = 1'b0;
    publish       = 1'b0;
    if (bus.stop) begin
      state_next = IDLE;
      idx_next   = '0;
      i_out_next = '0;
      clear_run  = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (bus.start && bus.ena) begin
            state_next    = HOLD;
            idx_next      = '0;
            i_out_next    = level_mem[0];
            hold_cnt_next = bus.cfg_hold;
            last_next     = bus.cfg_last;
            hold_next     = bus.cfg_hold;
            mode_next     = bus.cfg_mode;
            dir_down_next = 1'b0;
            clear_run     = 1'b1;
          end
        end
        HOLD: begin
          if (bus.ena) begin
            count_en = 1'b1;
            if (hold_cnt_reg != '0) begin
              hold_cnt_next = hold_cnt_reg - 1'b1;
            end else begin
              publish       = 1'b1;
              clear_run     = 1'b1;
              hold_cnt_next = hold_reg;
              if (one_shot && (idx_reg == last_reg)) begin
                state_next = DONE;
                idx_next   = '0;
                i_out_next = '0;
              end else begin
                idx_next      = adv_idx;
                dir_down_next = adv_dir_down;
                i_out_next    = level_mem[adv_idx];
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      last_reg      <= '0;
      hold_reg      <= '0;
      hold_cnt_reg  <= '0;
      mode_reg      <= '0;
      dir_down_reg  <= 1'b0;
      i_out_reg     <= '0;
      cnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_reg      <= last_next;
      hold_reg      <= hold_next;
      hold_cnt_reg  <= hold_cnt_next;
      mode_reg      <= mode_next;
      dir_down_reg  <= dir_down_next;
      i_out_reg     <= i_out_next;
      cnt_valid_reg <= publish;
    end
  end

  // Writes land via NBA, so a same-edge step load still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) level_mem[i] <= '0;
    end else if (bus.cfg_we) begin
      level_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < N_CH; c++) pop = pop + PW'(bus.spike_in[c]);
  end

  assign coinc_hit     = int'(pop) >= 2;
  assign coinc_run_inc = (coinc_hit && coinc_run_reg != CNT_MAX) ? coinc_run_reg + 1'b1
                                                                 : coinc_run_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coinc_run_reg <= '0;
      coinc_pub_reg <= '0;
    end else begin
      if (publish) coinc_pub_reg <= coinc_run_inc;
      if (clear_run) coinc_run_reg <= '0;
      else if (count_en) coinc_run_reg <= coinc_run_inc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] run_reg, pub_reg, run_inc;

      assign run_inc = (bus.spike_in[gi] && run_reg != CNT_MAX) ? run_reg + 1'b1 : run_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          run_reg <= '0;
          pub_reg <= '0;
        end else begin
          if (publish) pub_reg <= run_inc;
          if (clear_run) run_reg <= '0;
          else if (count_en) run_reg <= run_inc;
        end
      end

      assign bus.spike_cnt[gi*CNT_W +: CNT_W] = pub_reg;
    end
  endgenerate

  assign bus.i_out     = i_out_reg;
  assign bus.step_idx  = idx_reg;
  assign bus.busy      = (state_reg == HOLD);
  assign bus.done      = (state_reg == DONE);
  assign bus.cnt_valid = cnt_valid_reg;
  assign bus.coinc_cnt = coinc_pub_reg;
endmodule

// File: tb/tb_hh_stim_sequencer.sv
// Bench for hh_stim_sequencer: directed scenarios plus random traffic, all checked every
// cycle against a step-number based model; a CNT_W=2 copy exercises counter saturation.
module tb_hh_stim_sequencer;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int HOLD_W  = 16;
  localparam int N_CH    = 2;
  localparam int CNT_W   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SAT2    = 3;
  localparam int S_IDLE  = 0;
  localparam int S_HOLD  = 1;
  localparam int S_DONE  = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   fails  = 0;
  int   vcount = 0;

  always #5 clk = ~clk;

  hh_stim_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .N_CH(N_CH), .CNT_W(CNT_W)) bus ();
  hh_stim_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .N_CH(N_CH), .CNT_W(2)) bus2 ();

  assign bus2.ena      = bus.ena;
  assign bus2.cfg_we   = bus.cfg_we;
  assign bus2.cfg_addr = bus.cfg_addr;
  assign bus2.cfg_data = bus.cfg_data;
  assign bus2.cfg_last = bus.cfg_last;
  assign bus2.cfg_hold = bus.cfg_hold;
  assign bus2.cfg_mode = bus.cfg_mode;
  assign bus2.start    = bus.start;
  assign bus2.stop     = bus.stop;
  assign bus2.spike_in = bus.spike_in;

  hh_stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .N_CH(N_CH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  hh_stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .N_CH(N_CH), .CNT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(bus2));

  // Model: position in the sequence is just the step number n since start.
  int m_state, m_n, m_el, m_last, m_hold, m_mode, m_iout, m_valid;
  int tbl [DEPTH];
  int run_sp [N_CH];
  int pub_sp [N_CH];
  int run_co, pub_co;

  function automatic int idx_of(input int n);
    int p;
    if (m_mode == 1) return n % (m_last + 1);
    if (m_mode == 2) begin
      if (m_last == 0) return 0;
      p = n % (2 * m_last);
      return (p <= m_last) ? p : 2 * m_last - p;
    end
    return n;
  endfunction

  task automatic clear_run();
    for (int c = 0; c < N_CH; c++) run_sp[c] = 0;
    run_co = 0;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_n = 0; m_el = 0; m_last = 0; m_hold = 0; m_mode = 0;
    m_iout = 0; m_valid = 0; pub_co = 0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
    for (int c = 0; c < N_CH; c++) pub_sp[c] = 0;
    clear_run();
  endtask

  task automatic model_step();
    int pop;
    if (rst) begin
      model_reset();
    end else begin
      m_valid = 0;
      if (bus.stop) begin
        m_state = S_IDLE;
        m_iout  = 0;
        clear_run();
      end else if (m_state != S_HOLD) begin
        if (bus.start && bus.ena) begin
          m_last = int'(bus.cfg_last);
          m_hold = int'(bus.cfg_hold);
          m_mode = int'(bus.cfg_mode);
          m_n = 0; m_el = 0;
          clear_run();
          m_state = S_HOLD;
          m_iout  = tbl[0];
        end
      end else if (bus.ena) begin
        pop = 0;
        for (int c = 0; c < N_CH; c++) begin
          if (bus.spike_in[c]) begin
            pop++;
            if (run_sp[c] < CNT_MAX) run_sp[c]++;
          end
        end
        if (pop >= 2 && run_co < CNT_MAX) run_co++;
        if (m_el == m_hold) begin
          pub_sp = run_sp;
          pub_co = run_co;
          m_valid = 1;
          clear_run();
          m_n++;
          m_el = 0;
          if ((m_mode == 0 || m_mode == 3) && m_n > m_last) begin
            m_state = S_DONE;
            m_iout  = 0;
          end else begin
            m_iout = tbl[idx_of(m_n)];
          end
        end else begin
          m_el++;
        end
      end
      if (bus.cfg_we) tbl[bus.cfg_addr] = int'(bus.cfg_data);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.cnt_valid) vcount++;
        check("i_out", bus.i_out, m_iout);
        check("busy", bus.busy, m_state == S_HOLD);
        check("done", bus.done, m_state == S_DONE);
        check("cnt_valid", bus.cnt_valid, m_valid);
        check("coinc_cnt", bus.coinc_cnt, pub_co);
        check("sat_coinc", bus2.coinc_cnt, (pub_co > SAT2) ? SAT2 : pub_co);
        for (int c = 0; c < N_CH; c++) begin
          check("spike_cnt", bus.spike_cnt[c*CNT_W +: CNT_W], pub_sp[c]);
          check("sat_spike", bus2.spike_cnt[c*2 +: 2], (pub_sp[c] > SAT2) ? SAT2 : pub_sp[c]);
        end
        if (m_state == S_HOLD) check("step_idx", bus.step_idx, idx_of(m_n));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(a); bus.cfg_data = DATA_W'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_seq(input int mode, input int last, input int hold);
    bus.cfg_mode = 2'(mode); bus.cfg_last = AW'(last); bus.cfg_hold = HOLD_W'(hold);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic stop_seq();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  int pp_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int vc;

  initial begin
    rst = 1'b1;
    bus.ena = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.cfg_last = '0; bus.cfg_hold = '0; bus.cfg_mode = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.spike_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    $display("[TB] reset state");
    check("rst_i_out", bus.i_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnt_valid", bus.cnt_valid, 0);
    check("rst_spike_cnt", bus.spike_cnt, 0);
    check("rst_coinc", bus.coinc_cnt, 0);

    $display("[TB] one-shot 00..80, last=4 hold=2, spikes 11");
    for (int i = 0; i < 5; i++) write_entry(i, 32 * i);
    bus.spike_in = 2'b11;
    vc = vcount;
    start_seq(0, 4, 2);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 3; c++) begin
        check("oneshot_i_out", bus.i_out, 32 * s);
        tick();
      end
    end
    check("oneshot_done", bus.done, 1);
    check("oneshot_i_out_end", bus.i_out, 0);
    check("oneshot_spike", bus.spike_cnt, {16'd3, 16'd3});
    check("oneshot_coinc", bus.coinc_cnt, 3);
    tick();
    check("oneshot_pulses", vcount - vc, 5);

    $display("[TB] saturation, last=0 hold=9");
    start_seq(0, 0, 9);
    repeat (10) tick();
    check("sat16_spike", bus.spike_cnt, {16'd10, 16'd10});
    check("sat16_coinc", bus.coinc_cnt, 10);
    check("sat2_spike", bus2.spike_cnt, 4'b1111);
    check("sat2_coinc", bus2.coinc_cnt, 3);
    bus.spike_in = 2'b00;

    $display("[TB] loop last=1 hold=0 with ena freeze");
    write_entry(0, 8'h5A);
    start_seq(1, 1, 0);
    for (int j = 0; j < 6; j++) begin
      check("loop_i_out", bus.i_out, (j % 2) ? 8'h20 : 8'h5A);
      tick();
    end
    bus.ena = 1'b0;
    repeat (4) tick();
    check("freeze_i_out", bus.i_out, 8'h5A);
    bus.ena = 1'b1;
    tick();
    check("unfreeze_i_out", bus.i_out, 8'h20);
    stop_seq();
    check("loop_stop_i_out", bus.i_out, 0);
    check("loop_stop_busy", bus.busy, 0);

    $display("[TB] ping-pong last=3 and last=0");
    start_seq(2, 3, 0);
    for (int j = 0; j < 8; j++) begin
      check("pp_idx", bus.step_idx, pp_seq[j]);
      tick();
    end
    stop_seq();
    start_seq(2, 0, 0);
    for (int j = 0; j < 4; j++) begin
      check("pp0_idx", bus.step_idx, 0);
      check("pp0_busy", bus.busy, 1);
      tick();
    end
    stop_seq();

    $display("[TB] start+stop together, stop mid-step");
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("startstop_busy", bus.busy, 0);
    bus.spike_in = 2'b01;
    start_seq(0, 2, 5);
    repeat (2) tick();
    vc = vcount;
    stop_seq();
    check("midstop_i_out", bus.i_out, 0);
    check("midstop_busy", bus.busy, 0);
    check("midstop_valid", bus.cnt_valid, 0);
    repeat (3) tick();
    check("midstop_pulses", vcount - vc, 0);

    $display("[TB] reset mid-HOLD");
    start_seq(1, 1, 1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_i_out", bus.i_out, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_cnt_valid", bus.cnt_valid, 0);
    check("arst_spike_cnt", bus.spike_cnt, 0);
    tick();
    rst = 1'b0;
    start_seq(1, 1, 0);
    check("arst_tbl0", bus.i_out, 0);
    check("arst_busy_after", bus.busy, 1);
    tick();
    check("arst_tbl1", bus.i_out, 0);
    stop_seq();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      bus.ena      = ($urandom_range(0, 9) != 0);
      bus.spike_in = N_CH'($urandom);
      bus.cfg_we   = ($urandom_range(0, 4) == 0);
      bus.cfg_addr = AW'($urandom);
      bus.cfg_data = DATA_W'($urandom);
      bus.start    = ($urandom_range(0, 19) == 0);
      bus.stop     = ($urandom_range(0, 59) == 0);
      bus.cfg_mode = 2'($urandom);
      bus.cfg_last = AW'($urandom_range(0, DEPTH - 1));
      bus.cfg_hold = HOLD_W'($urandom_range(0, 3));
      tick();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
